// File: rtl/exe_mem_skid_reg.sv
// EXE->MEM pipeline register with a valid/ready handshake and a 2-entry skid buffer.
// in_ready comes only from state flops, so MEM back-pressure never forms a comb path into EXE.
module exe_mem_skid_reg #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wb_en,
  input  logic              in_mem_r_en,
  input  logic              in_mem_w_en,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_st_val,
  input  logic [DEST_W-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_wb_en,
  output logic              out_mem_r_en,
  output logic              out_mem_w_en,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_st_val,
  output logic [DEST_W-1:0] out_dest,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t state, state_next;
  logic head_valid, skid_valid, accept, take;
  logic load_head_in, load_head_skid, load_skid;

  logic              head_wb_en, head_mem_r_en, head_mem_w_en;
  logic [DATA_W-1:0] head_alu_result, head_st_val;
  logic [DEST_W-1:0] head_dest;
  logic              skid_wb_en, skid_mem_r_en, skid_mem_w_en;
  logic [DATA_W-1:0] skid_alu_result, skid_st_val;
  logic [DEST_W-1:0] skid_dest;

  assign head_valid = (state != EMPTY);
  assign skid_valid = (state == FULL);
  assign in_ready   = !skid_valid;
  assign out_valid  = head_valid;
  assign accept     = in_valid & in_ready;
  assign take       = out_valid & out_ready;
  assign occupancy  = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_next;
  end

  // Flush overrides everything; payload loads are suppressed so flops keep old contents.
  always_comb begin
    state_next     = state;
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          state_next   = ONE;
          load_head_in = 1'b1;
        end
        ONE: begin
          if (accept && take) begin
            load_head_in = 1'b1;
          end else if (accept) begin
            state_next = FULL;
            load_skid  = 1'b1;
          end else if (take) begin
            state_next = EMPTY;
          end
        end
        FULL: if (take) begin
          state_next     = ONE;
          load_head_skid = 1'b1;
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_wb_en      <= 1'b0;
      head_mem_r_en   <= 1'b0;
      head_mem_w_en   <= 1'b0;
      head_alu_result <= '0;
      head_st_val     <= '0;
      head_dest       <= '0;
    end else if (load_head_in) begin
      head_wb_en      <= in_wb_en;
      head_mem_r_en   <= in_mem_r_en;
      head_mem_w_en   <= in_mem_w_en;
      head_alu_result <= in_alu_result;
      head_st_val     <= in_st_val;
      head_dest       <= in_dest;
    end else if (load_head_skid) begin
      head_wb_en      <= skid_wb_en;
      head_mem_r_en   <= skid_mem_r_en;
      head_mem_w_en   <= skid_mem_w_en;
      head_alu_result <= skid_alu_result;
      head_st_val     <= skid_st_val;
      head_dest       <= skid_dest;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_wb_en      <= 1'b0;
      skid_mem_r_en   <= 1'b0;
      skid_mem_w_en   <= 1'b0;
      skid_alu_result <= '0;
      skid_st_val     <= '0;
      skid_dest       <= '0;
    end else if (load_skid) begin
      skid_wb_en      <= in_wb_en;
      skid_mem_r_en   <= in_mem_r_en;
      skid_mem_w_en   <= in_mem_w_en;
      skid_alu_result <= in_alu_result;
      skid_st_val     <= in_st_val;
      skid_dest       <= in_dest;
    end
  end

  // Side-effecting control bits are gated so a bubble never writes back or touches memory.
  assign out_wb_en      = head_wb_en & head_valid;
  assign out_mem_r_en   = head_mem_r_en & head_valid;
  assign out_mem_w_en   = head_mem_w_en & head_valid;
  assign out_alu_result = head_alu_result;
  assign out_st_val     = head_st_val;
  assign out_dest       = head_dest;

endmodule

// File: tb/tb_exe_mem_skid_reg.sv
// Bench for exe_mem_skid_reg: directed scenarios plus randomized valid/ready/flush
// traffic compared against a 2-deep FIFO queue model.
module tb_exe_mem_skid_reg;
  localparam int DW = 16;
  localparam int RW = 5;

  typedef struct {
    logic          wb, rd, wr;
    logic [DW-1:0] alu, st;
    logic [RW-1:0] dest;
  } ent_t;

  logic          clk = 1'b0, rst = 1'b0, flush = 1'b0;
  logic          in_valid = 1'b0, in_ready;
  logic          in_wb_en = 1'b0, in_mem_r_en = 1'b0, in_mem_w_en = 1'b0;
  logic [DW-1:0] in_alu_result = '0, in_st_val = '0;
  logic [RW-1:0] in_dest = '0;
  logic          out_valid, out_ready = 1'b0;
  logic          out_wb_en, out_mem_r_en, out_mem_w_en;
  logic [DW-1:0] out_alu_result, out_st_val;
  logic [RW-1:0] out_dest;
  logic [1:0]    occupancy;

  int vectors = 0;
  int errors  = 0;

  ent_t q[$];
  ent_t last_head;

  exe_mem_skid_reg #(.DATA_W(DW), .DEST_W(RW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_wb_en(in_wb_en), .in_mem_r_en(in_mem_r_en), .in_mem_w_en(in_mem_w_en),
    .in_alu_result(in_alu_result), .in_st_val(in_st_val), .in_dest(in_dest),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_wb_en(out_wb_en), .out_mem_r_en(out_mem_r_en), .out_mem_w_en(out_mem_w_en),
    .out_alu_result(out_alu_result), .out_st_val(out_st_val), .out_dest(out_dest),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  function automatic ent_t mk(logic wb, logic rd, logic wr, logic [DW-1:0] alu,
                              logic [DW-1:0] st, logic [RW-1:0] dest);
    ent_t e;
    e.wb = wb; e.rd = rd; e.wr = wr; e.alu = alu; e.st = st; e.dest = dest;
    return e;
  endfunction

  task automatic drive(input logic v, input ent_t e);
    in_valid      = v;
    in_wb_en      = e.wb;
    in_mem_r_en   = e.rd;
    in_mem_w_en   = e.wr;
    in_alu_result = e.alu;
    in_st_val     = e.st;
    in_dest       = e.dest;
  endtask

  // One clock: FIFO model decides accept/take from the inputs, then advances after the edge.
  task automatic cycle();
    bit   acc, tk, fl;
    ent_t e;
    acc = in_valid && (q.size() < 2);
    tk  = (q.size() > 0) && out_ready;
    fl  = flush;
    e   = mk(in_wb_en, in_mem_r_en, in_mem_w_en, in_alu_result, in_st_val, in_dest);
    @(posedge clk);
    #1;
    if (fl) q.delete();
    else begin
      if (tk) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    if (q.size() > 0) last_head = q[0];
  endtask

  task automatic test_reset();
    out_ready = 1'b0;
    drive(1'b1, mk(1, 0, 1, 16'h0AAA, 16'h0BBB, 5'd3));
    cycle();
    drive(1'b1, mk(1, 1, 0, 16'h0CCC, 16'h0DDD, 5'd4));
    cycle();
    drive(1'b0, mk(0, 0, 0, 0, 0, 0));
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    vectors++;
    if (out_wb_en !== 1'b0) begin errors++; $display("FAIL reset_out_wb_en got %0b want 0", out_wb_en); end
    vectors++;
    if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
    vectors++;
    if (out_alu_result !== '0) begin errors++; $display("FAIL reset_alu got %h want 0", out_alu_result); end
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    last_head = mk(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    vectors++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_pass_through();
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, mk(0, 0, 0, DW'(i), DW'(i * 16), RW'(i)));
      cycle();
      vectors++;
      if (out_valid !== 1'b1 || out_alu_result !== DW'(i)) begin
        errors++; $display("FAIL pass_alu%0d got v=%0b %h want v=1 %h", i, out_valid, out_alu_result, DW'(i));
      end
      vectors++;
      if (occupancy !== 2'd1) begin errors++; $display("FAIL pass_occ%0d got %0d want 1", i, occupancy); end
    end
    drive(1'b0, mk(0, 0, 0, 0, 0, 0));
    cycle();
    vectors++;
    if (occupancy !== 2'd0) begin errors++; $display("FAIL pass_drain got %0d want 0", occupancy); end
  endtask

  task automatic test_stall();
    logic [RW-1:0] want [3];
    want[0] = 5'd5; want[1] = 5'd6; want[2] = 5'd7;
    out_ready = 1'b0;
    drive(1'b1, mk(1, 0, 0, 16'hA000, 16'h0, 5'd5)); cycle();
    drive(1'b1, mk(1, 0, 0, 16'hB000, 16'h0, 5'd6)); cycle();
    vectors++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
      errors++; $display("FAIL stall_full got occ=%0d rdy=%0b want occ=2 rdy=0", occupancy, in_ready);
    end
    drive(1'b1, mk(1, 0, 0, 16'hC000, 16'h0, 5'd7)); cycle();
    vectors++;
    if (occupancy !== 2'd2 || out_dest !== 5'd5) begin
      errors++; $display("FAIL stall_hold got occ=%0d dest=%0d want occ=2 dest=5", occupancy, out_dest);
    end
    out_ready = 1'b1;
    // A leaves first; C is still being presented and enters once the skid frees.
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_dest !== want[i]) begin
        errors++; $display("FAIL stall_order%0d got v=%0b dest=%0d want v=1 dest=%0d", i, out_valid, out_dest, want[i]);
      end
      cycle();
      if (i == 1) drive(1'b0, mk(0, 0, 0, 0, 0, 0));
    end
    vectors++;
    if (occupancy !== 2'd0) begin errors++; $display("FAIL stall_drain got %0d want 0", occupancy); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, mk(0, 0, 1, 16'h1111, 16'h2222, 5'd1)); cycle();
    drive(1'b1, mk(0, 0, 1, 16'h3333, 16'h4444, 5'd2)); cycle();
    drive(1'b1, mk(1, 1, 1, 16'hDEAD, 16'hBEEF, 5'd9));
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    drive(1'b0, mk(0, 0, 0, 0, 0, 0));
    vectors++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_mem_w_en !== 1'b0) begin
      errors++; $display("FAIL flush_full got occ=%0d v=%0b w=%0b want 0 0 0", occupancy, out_valid, out_mem_w_en);
    end
    out_ready = 1'b1;
    cycle(); cycle();
    vectors++;
    if (out_valid !== 1'b0 || out_alu_result === 16'hDEAD) begin
      errors++; $display("FAIL flush_dropped got v=%0b alu=%h want v=0 alu!=dead", out_valid, out_alu_result);
    end
  endtask

  task automatic test_bubble();
    out_ready = 1'b1;
    drive(1'b1, mk(1, 0, 1, 16'h1234, 16'h5678, 5'd12)); cycle();
    drive(1'b0, mk(0, 0, 0, 0, 0, 0));
    vectors++;
    if (out_wb_en !== 1'b1 || out_mem_w_en !== 1'b1) begin
      errors++; $display("FAIL bubble_live got wb=%0b w=%0b want 1 1", out_wb_en, out_mem_w_en);
    end
    cycle();
    vectors++;
    if (out_valid !== 1'b0 || out_wb_en !== 1'b0 || out_mem_w_en !== 1'b0) begin
      errors++; $display("FAIL bubble_gate got v=%0b wb=%0b w=%0b want 0 0 0", out_valid, out_wb_en, out_mem_w_en);
    end
    vectors++;
    if (out_alu_result !== 16'h1234) begin
      errors++; $display("FAIL bubble_hold got %h want 1234", out_alu_result);
    end
  endtask

  task automatic test_random();
    logic rdy_a;
    logic [1:0] exp_occ;
    for (int n = 0; n < 10000; n++) begin
      drive($urandom_range(0, 3) != 0,
            mk(1'($urandom), 1'($urandom), 1'($urandom), DW'($urandom), DW'($urandom), RW'($urandom)));
      flush     = ($urandom_range(0, 63) == 0);
      out_ready = 1'b0;
      #1 rdy_a = in_ready;
      out_ready = 1'b1;
      #1;
      vectors++;
      if (in_ready !== rdy_a) begin
        errors++; $display("FAIL rand_comb_ready n=%0d got %0b want %0b", n, in_ready, rdy_a);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      cycle();
      exp_occ = 2'(q.size());
      vectors++;
      if (occupancy !== exp_occ || out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
        errors++; $display("FAIL rand_state n=%0d got occ=%0d v=%0b rdy=%0b want occ=%0d", n, occupancy, out_valid, in_ready, exp_occ);
      end
      vectors++;
      if (out_alu_result !== last_head.alu || out_st_val !== last_head.st || out_dest !== last_head.dest ||
          out_wb_en !== (last_head.wb & (q.size() > 0)) || out_mem_r_en !== (last_head.rd & (q.size() > 0)) ||
          out_mem_w_en !== (last_head.wr & (q.size() > 0))) begin
        errors++; $display("FAIL rand_head n=%0d got alu=%h st=%h dest=%0d wb=%0b r=%0b w=%0b want alu=%h st=%h dest=%0d",
                           n, out_alu_result, out_st_val, out_dest, out_wb_en, out_mem_r_en, out_mem_w_en,
                           last_head.alu, last_head.st, last_head.dest);
      end
    end
    flush = 1'b0;
  endtask

  initial begin
    last_head = mk(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #12 rst = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_pass_through();
    test_stall();
    test_flush();
    test_bubble();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
